array_window_sum: RTL and testbench



---
 rtl/array_window_sum_pkg.sv | 22 ++
 rtl/array_window_max.sv | 21 ++
 rtl/array_window_sum.sv | 142 ++++++++++++++
 tb/tb_array_window_sum.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/array_window_sum_pkg.sv
// Shared scalar types for the integer-stream model blocks.
package scam_model_types;
    typedef logic signed [31:0] sc_int_t;
endpackage

// Types and defaults for array_window_sum: FSM state, default window shape.
package array_window_sum_types;
    typedef enum logic [1:0] {
        READ     = 2'd0,
        EMIT_SUM = 2'd1,
        EMIT_MAX = 2'd2
    } array_window_sum_state_t;

    typedef int int_4[4];

    localparam int ARRAY_WINDOW_SUM_DEPTH_DEF = 4;

    // Index width for a DEPTH-entry window; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/array_window_max.sv
// Combinational signed maximum over a DEPTH-entry window.
// Zero latency; no flow control of its own.
module array_window_max
    import scam_model_types::*;
#(
    parameter int DEPTH = 4
) (
    input  sc_int_t i_arr [DEPTH],
    output sc_int_t o_max
);

    always_comb begin
        o_max = i_arr[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (i_arr[i] > o_max) begin
                o_max = i_arr[i];
            end
        end
    end

endmodule

// File: rtl/array_window_sum.sv
// Windowed wrapping sum of a signed 32-bit stream; ARRAY_WINDOW_SUM_MAX_EN adds the window max.
// Latency: sum valid the cycle after the DEPTH-th word; max follows one transfer later.
// Backpressure: holds b_out and refuses input while a result waits on b_out_sync.
module array_window_sum
    import scam_model_types::*;
    import array_window_sum_types::*;
#(
    parameter int DEPTH = ARRAY_WINDOW_SUM_DEPTH_DEF
) (
    input  logic    clk,
    input  logic    rst,
    input  sc_int_t b_in,
    input  logic    b_in_sync,
    output logic    b_in_notify,
    output sc_int_t b_out,
    input  logic    b_out_sync,
    output logic    b_out_notify
);

    localparam int             IW   = idx_width(DEPTH);
    localparam logic [IW-1:0]  LAST = IW'(DEPTH - 1);

    array_window_sum_state_t r_state;
    array_window_sum_state_t w_next_state;
    sc_int_t                 r_window [DEPTH];
    logic [IW-1:0]           r_wr_idx;
    sc_int_t                 r_acc;
    sc_int_t                 r_b_out;

    logic    w_in_xfer;
    logic    w_out_xfer;
    logic    w_last_word;
    sc_int_t w_sum;

`ifdef ARRAY_WINDOW_SUM_MAX_EN
    sc_int_t w_max;

    array_window_max #(
        .DEPTH (DEPTH)
    ) u_max (
        .i_arr (r_window),
        .o_max (w_max)
    );
`else
    // Sum-only builds never read the window back; fold it into a dead net.
    logic w_unused_window;

    always_comb begin
        w_unused_window = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_unused_window = w_unused_window ^ (^r_window[i]);
        end
    end
`endif

    assign w_in_xfer   = b_in_notify & b_in_sync;
    assign w_out_xfer  = b_out_notify & b_out_sync;
    assign w_last_word = (r_wr_idx == LAST);
    assign w_sum       = r_acc + b_in;
    assign b_out       = r_b_out;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            READ: begin
                if (w_in_xfer && w_last_word) begin
                    w_next_state = EMIT_SUM;
                end
            end
            EMIT_SUM: begin
                if (w_out_xfer) begin
`ifdef ARRAY_WINDOW_SUM_MAX_EN
                    w_next_state = EMIT_MAX;
`else
                    w_next_state = READ;
`endif
                end
            end
`ifdef ARRAY_WINDOW_SUM_MAX_EN
            EMIT_MAX: begin
                if (w_out_xfer) begin
                    w_next_state = READ;
                end
            end
`endif
            default: w_next_state = READ;
        endcase
    end

    // Handshake strobes decode the state register only, so they carry no input paths.
    always_comb begin
        b_in_notify  = (r_state == READ);
        b_out_notify = (r_state == EMIT_SUM) || (r_state == EMIT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= READ;
            r_wr_idx <= '0;
            r_acc    <= '0;
            r_b_out  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_window[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            case (r_state)
                READ: begin
                    if (w_in_xfer) begin
                        r_window[r_wr_idx] <= b_in;
                        r_acc              <= w_sum;
                        if (w_last_word) begin
                            r_wr_idx <= '0;
                            r_b_out  <= w_sum;
                        end else begin
                            r_wr_idx <= r_wr_idx + IW'(1);
                        end
                    end
                end
                EMIT_SUM: begin
                    if (w_out_xfer) begin
                        r_acc <= '0;
`ifdef ARRAY_WINDOW_SUM_MAX_EN
                        r_b_out <= w_max;
`endif
                    end
                end
`ifdef ARRAY_WINDOW_SUM_MAX_EN
                EMIT_MAX: begin
                    if (w_out_xfer) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            r_window[i] <= '0;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_array_window_sum.sv
// Bench for array_window_sum: table of windows plus hand sequences for stall and reset cases.
// Results are queued as windows complete and popped when a b_out transfer is seen.
module tb_array_window_sum;
    import array_window_sum_types::*;

    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] b_in;
    logic               b_in_sync;
    logic               b_in_notify;
    logic signed [31:0] b_out;
    logic               b_out_sync;
    logic               b_out_notify;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    typedef struct {
        int_4        w;
        int          gap;
        logic [31:0] sum;
        logic [31:0] mx;
    } vec_t;

    vec_t tbl[6];

    array_window_sum #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .b_in         (b_in),
        .b_in_sync    (b_in_sync),
        .b_in_notify  (b_in_notify),
        .b_out        (b_out),
        .b_out_sync   (b_out_sync),
        .b_out_notify (b_out_notify)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] v);
        bit done;
        done      = 1'b0;
        b_in      = v;
        b_in_sync = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (b_in_notify === 1'b1) begin
                tick();
                done = 1'b1;
                break;
            end
            tick();
        end
        b_in_sync = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL send_timeout: word %h not accepted, required acceptance within 50 cycles", v);
        end
    endtask

    task automatic push_result(input logic [31:0] sum, input logic [31:0] mx);
        exp_q.push_back(sum);
`ifdef ARRAY_WINDOW_SUM_MAX_EN
        exp_q.push_back(mx);
`else
        mx = mx;
`endif
    endtask

    task automatic wait_drained(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (exp_q.size() == 0 && b_in_notify === 1'b1) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s: drain timeout, %0d results outstanding, required 0", name, exp_q.size());
        end
    endtask

    // An output transfer completes at the next rising edge; compare mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b0 && b_out_notify === 1'b1 && b_out_sync === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got %h with no result expected", b_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_word", b_out, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0].w = '{1, 2, 3, 4};                  tbl[0].gap = 0; tbl[0].sum = 32'd10;        tbl[0].mx = 32'd4;
        tbl[1].w = '{32'h7FFF_FFFF, 1, 0, 0};      tbl[1].gap = 0; tbl[1].sum = 32'h8000_0000; tbl[1].mx = 32'h7FFF_FFFF;
        tbl[2].w = '{-3, 7, -1, 2};                tbl[2].gap = 0; tbl[2].sum = 32'd5;         tbl[2].mx = 32'd7;
        tbl[3].w = '{-1, -2, -3, -4};              tbl[3].gap = 1; tbl[3].sum = 32'hFFFF_FFF6; tbl[3].mx = 32'hFFFF_FFFF;
        tbl[4].w = '{10, 20, 30, 40};              tbl[4].gap = 2; tbl[4].sum = 32'd100;       tbl[4].mx = 32'd40;
        tbl[5].w = '{int'(32'h8000_0000), int'(32'h8000_0000), 0, 0};
        tbl[5].gap = 0; tbl[5].sum = 32'd0; tbl[5].mx = 32'd0;

        rst        = 1'b1;
        b_in       = '0;
        b_in_sync  = 1'b0;
        b_out_sync = 1'b1;
        tick();
        tick();
        check("rst_in_notify",  32'(b_in_notify),  32'd1);
        check("rst_out_notify", 32'(b_out_notify), 32'd0);
        check("rst_out",        b_out,             32'd0);
        rst = 1'b0;

        // First window: sum visible the cycle after the fourth word.
        for (int j = 0; j < DEPTH; j++) send_word(32'(j + 1));
        push_result(32'd10, 32'd4);
        check("a_in_notify",  32'(b_in_notify),  32'd0);
        check("a_out_notify", 32'(b_out_notify), 32'd1);
        check("a_out",        b_out,             32'd10);
        wait_drained("a_drain");

        // Back-pressure: result held, input pulses ignored.
        b_out_sync = 1'b0;
        for (int j = 0; j < DEPTH; j++) send_word(32'd5);
        push_result(32'd20, 32'd5);
        for (int i = 0; i < 5; i++) begin
            b_in      = 32'd99;
            b_in_sync = (i % 2 == 0);
            tick();
            check("b_hold_out",       b_out,             32'd20);
            check("b_hold_in_notify", 32'(b_in_notify),  32'd0);
            check("b_hold_notify",    32'(b_out_notify), 32'd1);
        end
        b_in_sync  = 1'b0;
        b_out_sync = 1'b1;
        tick();
`ifdef ARRAY_WINDOW_SUM_MAX_EN
        check("b_max_notify", 32'(b_out_notify), 32'd1);
        check("b_max_out",    b_out,             32'd5);
        tick();
`endif
        check("b_release_in_notify", 32'(b_in_notify), 32'd1);

        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < DEPTH; j++) begin
                send_word(tbl[r].w[j]);
                if (j == DEPTH - 1) push_result(tbl[r].sum, tbl[r].mx);
                else repeat (tbl[r].gap) tick();
            end
            wait_drained("tbl_drain");
        end

        // Reset mid-window discards the partial window.
        send_word(32'd7);
        send_word(32'd8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("c_in_notify", 32'(b_in_notify), 32'd1);
        for (int j = 0; j < DEPTH; j++) send_word(32'd1);
        push_result(32'd4, 32'd1);
        wait_drained("c_drain");

        // Reset while a result is pending drops it.
        b_out_sync = 1'b0;
        for (int j = 0; j < DEPTH; j++) send_word(32'd9);
        check("d_pend_notify", 32'(b_out_notify), 32'd1);
        check("d_pend_out",    b_out,             32'd36);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("d_rst_out_notify", 32'(b_out_notify), 32'd0);
        check("d_rst_out",        b_out,             32'd0);
        check("d_rst_in_notify",  32'(b_in_notify),  32'd1);
        b_out_sync = 1'b1;
        for (int j = 0; j < DEPTH; j++) send_word(32'd2);
        push_result(32'd8, 32'd2);
        wait_drained("d_drain");

        repeat (3) tick();
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
